// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: mode encodings and FSM states.
package alu_pkg;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_OR  = 4'd3;
  localparam logic [3:0] MODE_XOR = 4'd4;
  localparam logic [3:0] MODE_NOT = 4'd5;
  localparam logic [3:0] MODE_SHL = 4'd6;
  localparam logic [3:0] MODE_SHR = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SHIFT,
    HOLD
  } state_t;

  function automatic logic is_shift(input logic [3:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational arithmetic/logic unit for the single-cycle modes (add..not).
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] x,
  output logic             cout,
  output logic             ovf
);
  import alu_pkg::*;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;

  // Subtraction as a + ~b + 1 so the carry out reads as "no borrow".
  assign add_sum = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, cin};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    x    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (mode)
      MODE_ADD: begin
        x    = add_sum[WIDTH-1:0];
        cout = add_sum[WIDTH];
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      MODE_SUB: begin
        x    = sub_sum[WIDTH-1:0];
        cout = sub_sum[WIDTH];
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
      end
      MODE_AND: x = a & b;
      MODE_OR:  x = a | b;
      MODE_XOR: x = a ^ b;
      MODE_NOT: x = ~a;
      default:  x = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle arithmetic/logic modes plus a bit-serial shifter,
// result held until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);
  import alu_pkg::*;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, sh_reg, x_reg;
  logic [3:0]       mode_reg;
  logic             cin_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             cout_reg, zero_reg, neg_reg, ovf_reg, err_reg;

  logic [WIDTH-1:0] core_x;
  logic             core_cout, core_ovf;

  logic             accept;
  logic [SHW-1:0]   n_amt;
  logic             sh_done;
  logic [WIDTH-1:0] sh_shifted;
  logic             sh_bit;
  logic             load;
  logic [WIDTH-1:0] res_x;
  logic             res_cout, res_ovf, res_err;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .mode (mode_reg),
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .x    (core_x),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  assign accept  = (state_reg == IDLE) && in_valid;
  assign n_amt   = (b[SHW-1:0] > SHW'(WIDTH)) ? SHW'(WIDTH) : b[SHW-1:0];
  assign sh_done = (cnt_reg <= SHW'(1));

  assign sh_shifted = (mode_reg == MODE_SHL) ? {sh_reg[WIDTH-2:0], 1'b0}
                                             : {1'b0, sh_reg[WIDTH-1:1]};
  assign sh_bit     = (mode_reg == MODE_SHL) ? sh_reg[WIDTH-1] : sh_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    res_x      = '0;
    res_cout   = 1'b0;
    res_ovf    = 1'b0;
    res_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_shift(mode) ? SHIFT : CALC;
      end
      CALC: begin
        load       = 1'b1;
        res_err    = mode_reg[3];
        res_x      = mode_reg[3] ? '0   : core_x;
        res_cout   = mode_reg[3] ? 1'b0 : core_cout;
        res_ovf    = mode_reg[3] ? 1'b0 : core_ovf;
        state_next = HOLD;
      end
      SHIFT: begin
        // A zero count finishes immediately with the operand unchanged.
        res_x    = (cnt_reg == '0) ? sh_reg : sh_shifted;
        res_cout = (cnt_reg == '0) ? 1'b0   : sh_bit;
        if (sh_done) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sh_reg   <= '0;
      mode_reg <= '0;
      cin_reg  <= 1'b0;
      cnt_reg  <= '0;
      x_reg    <= '0;
      cout_reg <= 1'b0;
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
      ovf_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg    <= a;
        b_reg    <= b;
        sh_reg   <= a;
        mode_reg <= mode;
        cin_reg  <= cin;
        cnt_reg  <= n_amt;
      end
      if (state_reg == SHIFT && cnt_reg != '0) begin
        sh_reg  <= sh_shifted;
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (load) begin
        x_reg    <= res_x;
        cout_reg <= res_cout;
        ovf_reg  <= res_ovf;
        err_reg  <= res_err;
        zero_reg <= (res_x == '0);
        neg_reg  <= res_x[WIDTH-1];
      end
    end
  end

  assign x    = x_reg;
  assign cout = cout_reg;
  assign zero = zero_reg;
  assign neg  = neg_reg;
  assign ovf  = ovf_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] mode = 4'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       in_ready, out_valid, cout, zero, neg, ovf, err;
  logic [7:0] x;

  int passed = 0;
  int total  = 0;
  int lat;
  logic seen;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, let it be accepted, then scramble the inputs.
  task automatic send(input logic [3:0] m, input logic [7:0] av, input logic [7:0] bv,
                      input logic c);
    mode = m; a = av; b = bv; cin = c; in_valid = 1'b1;
    chk("in_ready_at_send", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = ~c; mode = 4'($urandom);
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (out_valid !== 1'b1 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    chk("out_valid_seen", out_valid, 1'b1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic res(input string tag, input logic [7:0] ex, input logic ec, input logic ez,
                     input logic en, input logic eo, input logic ee);
    chk({tag, ".x"},    x,    ex);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".zero"}, zero, ez);
    chk({tag, ".neg"},  neg,  en);
    chk({tag, ".ovf"},  ovf,  eo);
    chk({tag, ".err"},  err,  ee);
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    res("rst", 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;

    send(4'd0, 8'hFF, 8'h01, 1'b0);
    wait_out(lat); chk("add_ff.lat", lat, 1);
    res("add_ff", 8'h00, 1, 1, 0, 0, 0);
    take();
    chk("after_take.in_ready", in_ready, 1'b1);
    chk("after_take.out_valid", out_valid, 1'b0);

    send(4'd1, 8'h80, 8'h01, 1'b1);
    wait_out(lat); chk("sub_80.lat", lat, 1);
    res("sub_80", 8'h7F, 1, 0, 0, 1, 0);
    take();

    send(4'd0, 8'h7F, 8'h01, 1'b1);
    wait_out(lat); chk("add_7f.lat", lat, 1);
    res("add_7f", 8'h81, 0, 0, 1, 1, 0);

    mode = 4'd0; a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.x", x, 8'h81);
      chk("bp.flags", {cout, zero, neg, ovf, err}, 5'b00110);
      chk("bp.in_ready", in_ready, 1'b0);
      chk("bp.out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.idle_ready", in_ready, 1'b1);
    chk("bp.idle_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("bp.accepted", in_ready, 1'b0);
    in_valid = 1'b0; a = 8'hEE; b = 8'h77;
    wait_out(lat); chk("bp_add.lat", lat, 1);
    res("bp_add", 8'h02, 0, 0, 0, 0, 0);
    take();

    send(4'd2, 8'hF0, 8'h3C, 1'b1);
    wait_out(lat);
    res("and", 8'h30, 0, 0, 0, 0, 0);
    take();

    send(4'd5, 8'hFF, 8'h12, 1'b0);
    wait_out(lat);
    res("not", 8'h00, 0, 1, 0, 0, 0);
    take();

    send(4'd6, 8'h81, 8'h03, 1'b0);
    wait_out(lat); chk("shl3.lat", lat, 3);
    res("shl3", 8'h08, 0, 0, 0, 0, 0);
    take();

    send(4'd7, 8'h81, 8'h01, 1'b0);
    wait_out(lat); chk("shr1.lat", lat, 1);
    res("shr1", 8'h40, 1, 0, 0, 0, 0);
    take();

    send(4'd6, 8'h81, 8'h0F, 1'b0);
    wait_out(lat); chk("shl15.lat", lat, 8);
    res("shl15", 8'h00, 1, 1, 0, 0, 0);
    take();

    send(4'd6, 8'h81, 8'h00, 1'b0);
    wait_out(lat); chk("shl0.lat", lat, 1);
    res("shl0", 8'h81, 0, 0, 1, 0, 0);
    take();

    send(4'd6, 8'h81, 8'h06, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", in_ready, 1'b1);
    chk("midrst.out_valid", out_valid, 1'b0);
    res("midrst", 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("midrst.hold_ready", in_ready, 1'b1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("postrst.no_valid", seen, 1'b0);
    chk("postrst.in_ready", in_ready, 1'b1);
    res("postrst", 8'h00, 0, 0, 0, 0, 0);

    send(4'hA, 8'h55, 8'hAA, 1'b0);
    wait_out(lat); chk("illegal.lat", lat, 1);
    res("illegal", 8'h00, 0, 1, 0, 0, 1);
    take();

    send(4'd0, 8'h01, 8'h02, 1'b0);
    wait_out(lat);
    res("add_after_err", 8'h03, 0, 0, 0, 0, 0);
    take();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width; legal values are 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH)+1, sets the shift-amount field width taken from b.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 mode  input  4  operation select: 0 +, 1 -, 2 &, 3 |, 4 ^, 5 ~a, 6 <<, 7 >>, 8..15 illegal.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 cin  input  1  carry-in; used by mode 0 only.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 x  output  WIDTH  result.
REQ-013 cout, zero, neg, ovf, err  output  1 each  carry/no-borrow, x==0, x[WIDTH-1], signed overflow, illegal mode.

Function
REQ-014 The FSM SHALL have four states: IDLE, CALC, SHIFT and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015 When in_valid and in_ready are both high, the block SHALL register a, b, cin and mode, then enter CALC for modes 0-5 and 8-15, or SHIFT for modes 6-7.
REQ-016 CALC SHALL compute the result in one cycle and enter HOLD, so out_valid rises the cycle after acceptance.
REQ-017 Add SHALL compute a+b+cin; cout SHALL be the carry out of bit WIDTH-1; ovf SHALL be signed overflow.
REQ-018 Sub SHALL compute a+~b+1 with cin ignored; cout=1 SHALL mean no borrow; ovf SHALL be signed overflow.
REQ-019 Modes 2-5 SHALL set cout=0 and ovf=0.
REQ-020 Shift amount n SHALL be b[SHW-1:0] clamped to WIDTH.
REQ-021 SHIFT SHALL move the register one bit per cycle, logical with zero fill, over n cycles, giving a latency of max(n,1) cycles from acceptance to out_valid.
REQ-022 For shifts, cout SHALL be the last bit shifted out (0 when n=0), and ovf SHALL be 0.
REQ-023 Illegal modes SHALL give x=0, err=1, cout=0 and ovf=0 with CALC latency; err SHALL be 0 for every other mode.
REQ-024 zero and neg SHALL be derived from the final x for every mode.
REQ-025 In HOLD, out_valid=1, and x and all flags SHALL stay stable until out_ready=1.
REQ-026 On the out_valid and out_ready handshake, the FSM SHALL return to IDLE; in_ready rises the next cycle, with no same-cycle re-accept.
REQ-027 in_valid SHALL be ignored in every state except IDLE; operand changes after acceptance SHALL have no effect.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE and in_ready=1, and out_valid, x, cout, zero, neg, ovf and err SHALL all be 0.
REQ-029 Asserting rst in any state, including mid-SHIFT or HOLD, SHALL discard the in-flight operation with no result emitted.
REQ-030 After rst is released, the first rising edge SHALL be able to accept a request.

Structure
REQ-031 A shared package alu_pkg SHALL hold the mode encoding constants (MODE_ADD..MODE_SHR) and the state enum.
REQ-032 A combinational sub-module alu_core, parametrised by WIDTH, SHALL implement modes 0-5 and their flags; alu_seq SHALL own the FSM, the shifter register and the handshake.

Verification (WIDTH=8)
REQ-033 Add a=FF, b=01, cin=0 -> x=00, cout=1, zero=1, ovf=0, with out_valid 1 cycle after accept.
REQ-034 Sub a=80, b=01 -> x=7F, cout=1, ovf=1, neg=0; then add a=7F, b=01, cin=1 -> x=81, ovf=1, neg=1.
REQ-035 Shl a=81, b=3 -> x=08, cout=0, with out_valid 3 cycles after accept; shr a=81, b=1 -> x=40, cout=1 after 1 cycle; shl b=0F -> x=00, clamped at 8 cycles.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> x and flags stay constant, in_ready=0, and the new request is accepted only after the handshake plus 1 cycle.
REQ-037 Assert rst 2 cycles into a shl b=6 -> out_valid never rises for that request, all outputs read 0, and in_ready=1 during and after reset.
REQ-038 mode=A, a=55, b=AA -> x=00, err=1, zero=1; the following legal add returns err=0.
